ahbl_arbiter: RTL

AHBL_ARBITER -- requirements
Module: ahbl_arbiter

---
 rtl/ahbl_arbiter_if.sv | 43 ++++
 rtl/ahbl_arbiter.sv | 74 +++++++
 2 files changed

// File: rtl/ahbl_arbiter_if.sv
// ahbl_arbiter_if: upstream master ports and downstream splitter port of the AHB-Lite arbiter
interface ahbl_arbiter_if #(
  parameter int N_PORTS = 2,
  parameter int W_ADDR  = 32,
  parameter int W_DATA  = 32
);
  logic [N_PORTS-1:0]        src_hready;
  logic [N_PORTS-1:0]        src_hready_resp;
  logic [N_PORTS-1:0]        src_hresp;
  logic [N_PORTS*W_ADDR-1:0] src_haddr;
  logic [N_PORTS-1:0]        src_hwrite;
  logic [N_PORTS*2-1:0]      src_htrans;
  logic [N_PORTS*3-1:0]      src_hsize;
  logic [N_PORTS*3-1:0]      src_hburst;
  logic [N_PORTS*4-1:0]      src_hprot;
  logic [N_PORTS-1:0]        src_hmastlock;
  logic [N_PORTS*W_DATA-1:0] src_hwdata;
  logic [N_PORTS*W_DATA-1:0] src_hrdata;
  logic                      dst_hready;
  logic                      dst_hready_resp;
  logic                      dst_hresp;
  logic [W_ADDR-1:0]         dst_haddr;
  logic                      dst_hwrite;
  logic [1:0]                dst_htrans;
  logic [2:0]                dst_hsize;
  logic [2:0]                dst_hburst;
  logic [3:0]                dst_hprot;
  logic                      dst_hmastlock;
  logic [W_DATA-1:0]         dst_hwdata;
  logic [W_DATA-1:0]         dst_hrdata;
  modport slave (
    input  src_hready, src_haddr, src_hwrite, src_htrans, src_hsize, src_hburst, src_hprot,
           src_hmastlock, src_hwdata, dst_hready_resp, dst_hresp, dst_hrdata,
    output src_hready_resp, src_hresp, src_hrdata, dst_hready, dst_haddr, dst_hwrite,
           dst_htrans, dst_hsize, dst_hburst, dst_hprot, dst_hmastlock, dst_hwdata
  );
  modport master (
    output src_hready, src_haddr, src_hwrite, src_htrans, src_hsize, src_hburst, src_hprot,
           src_hmastlock, src_hwdata, dst_hready_resp, dst_hresp, dst_hrdata,
    input  src_hready_resp, src_hresp, src_hrdata, dst_hready, dst_haddr, dst_hwrite,
           dst_htrans, dst_hsize, dst_hburst, dst_hprot, dst_hmastlock, dst_hwdata
  );
endinterface

// File: rtl/ahbl_arbiter.sv
// ahbl_arbiter: fixed-priority N-to-1 AHB-Lite arbiter with lock override and one-deep per-port request buffer
module ahbl_arbiter #(
  parameter int N_PORTS = 2,
  parameter int W_ADDR  = 32,
  parameter int W_DATA  = 32
) (
  input  logic clk,
  input  logic rst,
  ahbl_arbiter_if.slave bus
);
  localparam int W_IDX = N_PORTS > 1 ? $clog2(N_PORTS) : 1;
  localparam int W_AP  = W_ADDR + 14;
  logic [N_PORTS-1:0] live, pend, buf_valid_q, buf_valid_d, hr_resp, h_err;
  logic [W_AP-1:0]    src_ap [N_PORTS];
  logic [W_AP-1:0]    buf_q  [N_PORTS];
  logic [W_AP-1:0]    sel, ap, hold_q;
  logic [W_IDX-1:0]   gnt_idx, lock_idx_q, dph_idx_q;
  logic               gnt, lock_v_q, dph_v_q;
  // address phase packed as {haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock}
  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      src_ap[i] = {bus.src_haddr[i*W_ADDR +: W_ADDR], bus.src_hwrite[i], bus.src_htrans[2*i +: 2],
                   bus.src_hsize[3*i +: 3], bus.src_hburst[3*i +: 3], bus.src_hprot[4*i +: 4],
                   bus.src_hmastlock[i]};
      live[i] = bus.src_htrans[2*i+1] & bus.src_hready[i];
    end
    pend = buf_valid_q | live;
    gnt_idx = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) gnt_idx = pend[i] ? W_IDX'(i) : gnt_idx;
    gnt_idx = lock_v_q && pend[lock_idx_q] ? lock_idx_q : gnt_idx;
    gnt = bus.dst_hready_resp & |pend & ~rst;
    sel = buf_valid_q[gnt_idx] ? buf_q[gnt_idx] : src_ap[gnt_idx];
    ap = gnt ? sel : hold_q;
    for (int i = 0; i < N_PORTS; i++) begin
      buf_valid_d[i] = N_PORTS > 1 && !(gnt && gnt_idx == W_IDX'(i)) && pend[i];
      hr_resp[i] = rst | (~buf_valid_q[i] & (~(dph_v_q && dph_idx_q == W_IDX'(i)) | bus.dst_hready_resp));
      h_err[i] = ~rst & dph_v_q & (dph_idx_q == W_IDX'(i)) & bus.dst_hresp;
    end
  end
  assign bus.dst_haddr       = ap[W_AP-1 -: W_ADDR];
  assign bus.dst_hwrite      = ap[13];
  assign bus.dst_htrans      = gnt ? ap[12:11] : 2'b00;
  assign bus.dst_hsize       = ap[10:8];
  assign bus.dst_hburst      = ap[7:5];
  assign bus.dst_hprot       = ap[4:1];
  assign bus.dst_hmastlock   = ap[0];
  assign bus.dst_hwdata      = dph_v_q ? bus.src_hwdata[dph_idx_q*W_DATA +: W_DATA] : '0;
  assign bus.dst_hready      = bus.dst_hready_resp;
  assign bus.src_hrdata      = {N_PORTS{bus.dst_hrdata}};
  assign bus.src_hready_resp = hr_resp;
  assign bus.src_hresp       = h_err;
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_q <= '0;
      lock_v_q    <= 1'b0;
      lock_idx_q  <= '0;
      dph_v_q     <= 1'b0;
      dph_idx_q   <= '0;
      hold_q      <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      for (int i = 0; i < N_PORTS; i++) if (!buf_valid_q[i]) buf_q[i] <= src_ap[i];
      if (bus.dst_hready_resp) begin
        dph_v_q   <= gnt;
        dph_idx_q <= gnt_idx;
      end
      if (gnt) begin
        lock_v_q   <= sel[0];
        lock_idx_q <= gnt_idx;
        hold_q     <= sel;
      end
    end
  end
endmodule
